// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock).
// Produces packed decimal digits plus a leading-zero blank mask for the display.
module bin_to_bcd_seq #(
    parameter int IN_W   = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [IN_W-1:0]       bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     blank
);

    localparam int SR_W  = 4*DIGITS + IN_W;
    localparam int CNT_W = $clog2(IN_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_W - 1);
    localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic [IN_W-1:0]       bin_q, bin_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic [4*DIGITS-1:0]   bcd_out_q, bcd_out_d;
    logic [DIGITS-1:0]     blank_q, blank_d;

    logic [4*DIGITS-1:0]   bcd_adj;
    logic [SR_W-1:0]       sr_adj;
    logic [SR_W-1:0]       sr_next;
    logic [4*DIGITS-1:0]   bcd_fin;
    logic [DIGITS-1:0]     mask;
    logic                  zero_run;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bcd_q     <= '0;
            bin_q     <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            bcd_out_q <= '0;
            blank_q   <= BLANK_RST;
        end else begin
            state_q   <= state_d;
            bcd_q     <= bcd_d;
            bin_q     <= bin_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            bcd_out_q <= bcd_out_d;
            blank_q   <= blank_d;
        end
    end

    // Add-3 correction on every digit >= 5, then one left shift of {bcd, bin}.
    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
            end
        end
        sr_adj  = {bcd_adj, bin_q};
        sr_next = sr_adj << 1;
        bcd_fin = sr_next[SR_W-1 -: 4*DIGITS];
    end

    // A digit is dark only when it and every more significant digit are zero.
    always_comb begin
        mask     = '0;
        zero_run = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_run = zero_run & (bcd_fin[4*k +: 4] == 4'd0);
            mask[k]  = zero_run;
        end
    end

    always_comb begin
        state_d   = state_q;
        bcd_d     = bcd_q;
        bin_d     = bin_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        bcd_out_d = bcd_out_q;
        blank_d   = blank_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d   = bin_in;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d = bcd_fin;
                bin_d = sr_next[IN_W-1:0];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d   = IDLE;
                    done_d    = 1'b1;
                    bcd_out_d = bcd_fin;
                    blank_d   = mask;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy    = (state_q == SHIFT);
    assign done    = done_q;
    assign bcd_out = bcd_out_q;
    assign blank   = blank_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: decimal reference model, directed vectors and a value sweep.
module tb_bin_to_bcd_seq;

    localparam int IN_W   = 16;
    localparam int DIGITS = 5;

    logic                clk;
    logic                rst_n;
    logic                start;
    logic [IN_W-1:0]     bin_in;
    logic                busy;
    logic                done;
    logic [4*DIGITS-1:0] bcd_out;
    logic [DIGITS-1:0]   blank;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    logic [IN_W-1:0] exp_q[$];

    bin_to_bcd_seq #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out),
        .blank   (blank)
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [4*DIGITS-1:0] model_bcd(input int v);
        logic [4*DIGITS-1:0] r;
        int p;
        r = '0;
        p = 1;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [DIGITS-1:0] model_blank(input int v);
        logic [DIGITS-1:0] r;
        int p;
        r = '0;
        p = 10;
        for (int k = 1; k < DIGITS; k++) begin
            r[k] = (v < p);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    // ---------------- scoreboard / compare ----------------
    always @(negedge clk) begin
        logic [IN_W-1:0] v;
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                chk_cnt++;
                $display("FAIL spurious_done: got done=1 with bcd 0x%0h, required no done", bcd_out);
            end else begin
                v = exp_q.pop_front();
                check("model_bcd", 32'(bcd_out), 32'(model_bcd(int'(v))));
                check("model_blank", 32'(blank), 32'(model_blank(int'(v))));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_conv(input logic [IN_W-1:0] v, output int lat, output int bcnt);
        lat  = -1;
        bcnt = 0;
        @(negedge clk);
        start  = 1'b1;
        bin_in = v;
        exp_q.push_back(v);
        @(posedge clk);
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (n == 1) begin
                start  = 1'b0;
                bin_in = 16'($urandom);
            end
            if (busy) bcnt++;
            if (done) begin
                lat = n - 1;
                break;
            end
        end
        if (lat < 0) begin
            chk_cnt++;
            $display("FAIL timeout: no done for value %0d within 100 cycles, required done", v);
        end
    endtask

    task automatic count_dones(input int cycles, output int cnt);
        cnt = 0;
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk);
            if (done) cnt++;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat, bcnt, extra, d1, d2;
        logic [IN_W-1:0] edge_vals[8];

        rst_n  = 1'b0;
        start  = 1'b0;
        bin_in = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bcd", 32'(bcd_out), 32'h0);
        check("rst_blank", 32'(blank), 32'b11110);
        rst_n = 1'b1;

        // 460: latency, busy width and literal result
        run_conv(16'd460, lat, bcnt);
        check("lat_460", 32'(lat), 32'd16);
        check("busy_460", 32'(bcnt), 32'd16);
        check("bcd_460", 32'(bcd_out), 32'h00460);
        check("blank_460", 32'(blank), 32'b11000);

        run_conv(16'd0, lat, bcnt);
        check("bcd_0", 32'(bcd_out), 32'h00000);
        check("blank_0", 32'(blank), 32'b11110);

        run_conv(16'd65535, lat, bcnt);
        check("bcd_65535", 32'(bcd_out), 32'h65535);
        check("blank_65535", 32'(blank), 32'b00000);

        // outputs hold between conversions
        repeat (5) @(negedge clk);
        check("hold_bcd", 32'(bcd_out), 32'h65535);
        check("hold_busy", 32'(busy), 32'd0);

        // 1234 with a second start pulse and bin_in change while busy
        lat = -1;
        @(negedge clk);
        start  = 1'b1;
        bin_in = 16'd1234;
        exp_q.push_back(16'd1234);
        @(posedge clk);
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (n == 3) start = 1'b1;
            if (n == 4) start = 1'b0;
            if (n == 5) bin_in = 16'd9;
            if (done) begin
                lat = n - 1;
                break;
            end
        end
        check("lat_1234", 32'(lat), 32'd16);
        check("bcd_1234", 32'(bcd_out), 32'h01234);
        check("blank_1234", 32'(blank), 32'b10000);
        count_dones(20, extra);
        check("ignored_start", 32'(extra), 32'd0);

        // back-to-back with start held high
        d1 = -1;
        d2 = -1;
        @(negedge clk);
        start  = 1'b1;
        bin_in = 16'd10;
        exp_q.push_back(16'd10);
        @(posedge clk);
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (n == 1) bin_in = 16'd99;
            if (d1 > 0 && n == d1 + 1) start = 1'b0;
            if (done) begin
                if (d1 < 0) begin
                    d1 = n;
                    exp_q.push_back(16'd99);
                    check("b2b_bcd_10", 32'(bcd_out), 32'h00010);
                end else begin
                    d2 = n;
                    check("b2b_bcd_99", 32'(bcd_out), 32'h00099);
                    break;
                end
            end
        end
        start = 1'b0;
        check("b2b_first_lat", 32'(d1), 32'd17);
        check("b2b_gap", 32'(d2 - d1), 32'd17);

        // reset in the middle of a conversion of 4321
        @(negedge clk);
        start  = 1'b1;
        bin_in = 16'd4321;
        exp_q.push_back(16'd4321);
        @(posedge clk);
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
        end
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_bcd", 32'(bcd_out), 32'h0);
        check("midrst_blank", 32'(blank), 32'b11110);
        count_dones(20, extra);
        check("midrst_no_done", 32'(extra), 32'd0);
        run_conv(16'd4321, lat, bcnt);
        check("bcd_4321", 32'(bcd_out), 32'h04321);
        check("blank_4321", 32'(blank), 32'b10000);

        // decade boundaries, then a value sweep against the model
        edge_vals = '{16'd9, 16'd10, 16'd99, 16'd100, 16'd999, 16'd1000, 16'd9999, 16'd10000};
        for (int i = 0; i < 8; i++) begin
            run_conv(edge_vals[i], lat, bcnt);
            check("lat_edge", 32'(lat), 32'd16);
        end
        for (int i = 0; i < 1000; i++) begin
            run_conv(16'($urandom_range(0, 65535)), lat, bcnt);
            check("lat_sweep", 32'(lat), 32'd16);
        end

        repeat (3) @(negedge clk);
        check("pending_expected", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
- Sits directly downstream of the 8x8 multiplier stage.
- Consumes the 16-bit product and produces packed decimal digits plus a leading-zero blank mask for the seven-segment decoders.
- Lets the board show the product in decimal instead of hex.

Parameters:
- IN_W, 16, width of the binary input in bits.
- DIGITS, 5, number of BCD digits produced. Must satisfy 10^DIGITS > 2^IN_W - 1; the defaults give a maximum of 65535.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- start  input  1  conversion request, sampled only in IDLE.
- bin_in  input  IN_W  unsigned binary value, captured on the accepting edge.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd_out and blank are updated.
- bcd_out  output  4*DIGITS  packed BCD; digit 0 (ones) is bits [3:0], digit k is bits [4k+3:4k].
- blank  output  DIGITS  per-digit leading-zero flag; blank[k]=1 means digit k should be dark.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; busy=0, done=0, bcd_out=0.
  - blank = all ones except blank[0]=0.
  - Internal shift register and bit counter cleared.
  - Reset has priority over start and over any conversion in flight; a partial result is discarded and never appears on bcd_out.
- States: IDLE, SHIFT.
- IDLE:
  - start=1 at edge E0: load bin_in into the binary field of the shift register, clear the BCD field, counter=0, state=SHIFT, busy=1.
  - start=0: hold all outputs.
- SHIFT, each edge:
  - For every BCD digit field >= 5, add 3 (4-bit, no carry out of the field).
  - Then shift the whole {bcd, bin} register left by 1.
  - counter increments.
- On the edge performing shift number IN_W (edge E_IN_W):
  - bcd_out <= final BCD field; blank <= computed mask; done <= 1; busy <= 0; state=IDLE.
- Latency: done is high in the cycle following edge E_IN_W, i.e. exactly IN_W cycles after the accepting edge (16 by default). busy is high for exactly IN_W cycles.
- done is high for one cycle only; it deasserts on the next edge unless reset intervenes (reset forces 0).
- start while busy=1 is ignored entirely. No queuing; bin_in changes during SHIFT have no effect.
- start=1 in the IDLE cycle where done=1 is accepted normally, so back-to-back conversions are possible every IN_W+1 cycles.
- bcd_out and blank hold their last value between conversions and never show intermediate values.
- Blank mask, computed from the final digits: blank[k]=1 iff digit k and every higher digit are zero. blank[0] is always 0, so value 0 displays as a single "0".
- Every digit of bcd_out is always in 0..9 for any input in 0..2^IN_W-1.

Test Plan:
- Reset, then start with bin_in=460 (20*23) -> done exactly 16 cycles after the accepting edge; bcd_out=0x00460; blank=5'b11000; busy high for exactly 16 cycles.
- bin_in=0 -> bcd_out=0x00000, blank=5'b11110. bin_in=65535 -> bcd_out=0x65535, blank=5'b00000.
- bin_in=1234, then pulse start again and change bin_in to 9 on cycle 5 of the conversion -> bcd_out=0x01234, blank=5'b10000; exactly one done pulse; the second start is ignored.
- Back-to-back: start=1 held continuously with bin_in=10, then 99 -> done pulses 17 cycles apart; outputs 0x00010 then 0x00099.
- rst_n=0 for one edge at cycle 8 of a conversion of 4321 -> busy=0, done=0, bcd_out=0 on the next cycle; no done pulse follows; a fresh start of 4321 yields 0x04321.
- Randomised sweep of 1000 values checked against a reference decimal model -> every digit in 0..9 and every blank mask correct.
